// File: rtl/microprocessor_top_pkg.sv
// rtl/microprocessor_top_pkg.sv - shared types, opcodes, reset table and glyphs for the micro-sequencer
package microprocessor_top_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S_OP  = 3'd1,
        S_RD1 = 3'd2,
        S_RD2 = 3'd3,
        S_WR  = 3'd4,
        DONE  = 3'd5
    } state_e;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_LOADI = 4'd1;
    localparam logic [3:0] OP_READ  = 4'd2;
    localparam logic [3:0] OP_COPY  = 4'd3;
    localparam logic [3:0] OP_NOT   = 4'd4;
    localparam logic [3:0] OP_AND   = 4'd5;
    localparam logic [3:0] OP_OR    = 4'd6;
    localparam logic [3:0] OP_XOR   = 4'd7;
    localparam logic [3:0] OP_NAND  = 4'd8;
    localparam logic [3:0] OP_NOR   = 4'd9;
    localparam logic [3:0] OP_ADD   = 4'd10;
    localparam logic [3:0] OP_SUB   = 4'd11;
    localparam logic [3:0] OP_SHL   = 4'd12;
    localparam logic [3:0] OP_SHR   = 4'd13;
    localparam logic [3:0] OP_ADDI  = 4'd14;
    localparam logic [3:0] OP_SUBI  = 4'd15;

    // Segment patterns are {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;
    localparam logic [6:0] GLYPH_DASH  = 7'h3F;
    localparam logic [6:0] GLYPH_D     = 7'h21;

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // R[i] = i, except R[13] which powers up holding 3
    function automatic logic [3:0] rf_reset_val(input int idx);
        return (idx == 13) ? 4'd3 : idx[3:0];
    endfunction

endpackage

// File: rtl/microprocessor_top_if.sv
// rtl/microprocessor_top_if.sv - board-side bundle of buttons, switches, leds and display lines
interface microprocessor_top_if;
    logic [3:0] btn;
    logic [3:0] sw;
    logic [3:0] led;
    logic [6:0] ssd_seg;
    logic [3:0] ssd_anode;

    modport master (output btn, output sw, input led, input ssd_seg, input ssd_anode);
    modport slave  (input btn, input sw, output led, output ssd_seg, output ssd_anode);
endinterface

// File: rtl/microprocessor_top_button.sv
// rtl/microprocessor_top_button.sv - push-button synchroniser, debouncer and rising-edge pulse
module microprocessor_top_button #(
    parameter int DEBOUNCE_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic pulse_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          meta_q, sync_q, stable_q, pulse_q;
    logic [CW-1:0] cnt_q;

    // The counter only runs while the synchronised level disagrees with the accepted one
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            meta_q  <= btn_i;
            sync_q  <= meta_q;
            pulse_q <= 1'b0;
            if (sync_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt_q    <= '0;
                stable_q <= sync_q;
                pulse_q  <= sync_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign pulse_o = pulse_q;
endmodule

// File: rtl/microprocessor_top_ssd.sv
// rtl/microprocessor_top_ssd.sv - four-digit multiplexed seven-segment driver
module microprocessor_top_ssd
    import microprocessor_top_pkg::*;
#(
    parameter int REFRESH_CYCLES = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            enable_i,
    input  logic [3:0][6:0] glyph_i,
    output logic [6:0]      seg_o,
    output logic [3:0]      anode_o
);
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    logic [RW-1:0] tick_q;
    logic [1:0]    digit_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tick_q  <= '0;
            digit_q <= 2'd0;
        end else if (tick_q == RW'(REFRESH_CYCLES - 1)) begin
            tick_q  <= '0;
            digit_q <= digit_q + 2'd1;
        end else begin
            tick_q <= tick_q + 1'b1;
        end
    end

    always_comb begin
        anode_o = 4'hF;
        seg_o   = GLYPH_BLANK;
        if (enable_i) begin
            anode_o[digit_q] = 1'b0;
            seg_o            = glyph_i[digit_q];
        end
    end
endmodule

// File: rtl/microprocessor_top.sv
// rtl/microprocessor_top.sv - 4-bit micro-sequencer: field entry FSM, ALU, 16x4 register file, display
module microprocessor_top
    import microprocessor_top_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 256,
    parameter int REFRESH_CYCLES  = 64
) (
    input  logic       clk_ref,
    input  logic [3:0] btn,
    input  logic [3:0] sw,
    output logic [3:0] led,
    output logic [6:0] ssd_seg,
    output logic [3:0] ssd_anode
);
    logic            rst_meta_q, rst_q;
    logic            step_pulse, view_pulse, unused_btn2;
    state_e          state_q, state_d;
    logic [3:0]      op_q, op_d, rd1_q, rd1_d, rd2_q, rd2_d, wr_q, wr_d;
    logic [4:0]      result_q;
    logic            ovf_q, unf_q, view_q, view_d, exec;
    logic [3:0]      rf_q [16];
    logic [3:0]      a, b, mag;
    logic [4:0]      alu_res;
    logic            alu_ovf, alu_unf, alu_we, disp_en;
    logic [3:0][6:0] glyphs;

    assign unused_btn2 = btn[2];

    // Reset is only synchronised so it acts while the button is held
    always_ff @(posedge clk_ref) begin
        rst_meta_q <= btn[3];
        rst_q      <= rst_meta_q;
    end

    microprocessor_top_button #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
        .clk_i(clk_ref), .rst_i(rst_q), .btn_i(btn[0]), .pulse_o(step_pulse)
    );

    microprocessor_top_button #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_view (
        .clk_i(clk_ref), .rst_i(rst_q), .btn_i(btn[1]), .pulse_o(view_pulse)
    );

    // A step pulse takes priority over a view toggle arriving in the same cycle
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        wr_d    = wr_q;
        view_d  = view_q;
        exec    = 1'b0;
        if (step_pulse) begin
            case (state_q)
                IDLE:  state_d = S_OP;
                S_OP:  begin op_d  = sw; state_d = S_RD1; end
                S_RD1: begin rd1_d = sw; state_d = S_RD2; end
                S_RD2: begin rd2_d = sw; state_d = S_WR;  end
                S_WR:  begin wr_d  = sw; exec = 1'b1; state_d = DONE; end
                DONE:  begin view_d = 1'b0; state_d = IDLE; end
                default: state_d = IDLE;
            endcase
        end else if (view_pulse && state_q == DONE) begin
            view_d = ~view_q;
        end
    end

    always_comb begin
        a       = rf_q[rd1_q];
        b       = rf_q[rd2_q];
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_unf = 1'b0;
        alu_we  = 1'b1;
        case (op_q)
            OP_NOP:   alu_we = 1'b0;
            OP_LOADI: alu_res = {1'b0, rd2_q};
            OP_READ:  begin alu_res = {1'b0, a}; alu_we = 1'b0; end
            OP_COPY:  alu_res = {1'b0, a};
            OP_NOT:   alu_res = {1'b0, ~a};
            OP_AND:   alu_res = {1'b0, a & b};
            OP_OR:    alu_res = {1'b0, a | b};
            OP_XOR:   alu_res = {1'b0, a ^ b};
            OP_NAND:  alu_res = {1'b0, ~(a & b)};
            OP_NOR:   alu_res = {1'b0, ~(a | b)};
            OP_ADD:   begin alu_res = {1'b0, a} + {1'b0, b}; alu_ovf = alu_res[4]; end
            OP_SUB:   begin alu_res = {1'b0, a - b}; alu_unf = (a < b); end
            OP_SHL:   begin alu_res = {a, 1'b0}; alu_ovf = a[3]; end
            OP_SHR:   alu_res = {2'b00, a[3:1]};
            OP_ADDI:  begin alu_res = {1'b0, a} + {1'b0, rd2_q}; alu_ovf = alu_res[4]; end
            OP_SUBI:  begin alu_res = {1'b0, a - rd2_q}; alu_unf = (a < rd2_q); end
            default:  alu_we = 1'b0;
        endcase
    end

    // The write uses the destination index being latched on this same edge
    always_ff @(posedge clk_ref) begin
        if (rst_q) begin
            state_q  <= IDLE;
            op_q     <= 4'd0;
            rd1_q    <= 4'd0;
            rd2_q    <= 4'd0;
            wr_q     <= 4'd0;
            result_q <= 5'd0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            view_q   <= 1'b0;
            for (int i = 0; i < 16; i++) rf_q[i] <= rf_reset_val(i);
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            wr_q    <= wr_d;
            view_q  <= view_d;
            if (exec) begin
                result_q <= alu_res;
                ovf_q    <= alu_ovf;
                unf_q    <= alu_unf;
                if (alu_we) rf_q[wr_d] <= alu_res[3:0];
            end
        end
    end

    always_comb begin
        led     = 4'b0000;
        glyphs  = {4{GLYPH_BLANK}};
        disp_en = 1'b1;
        mag     = unf_q ? 4'd0 - result_q[3:0] : result_q[3:0];
        case (state_q)
            S_OP:  begin led = 4'b0001; glyphs[3] = hex_glyph(4'd1); glyphs[0] = hex_glyph(sw); end
            S_RD1: begin led = 4'b0010; glyphs[3] = hex_glyph(4'd2); glyphs[0] = hex_glyph(sw); end
            S_RD2: begin led = 4'b0100; glyphs[3] = hex_glyph(4'd3); glyphs[0] = hex_glyph(sw); end
            S_WR:  begin led = 4'b1000; glyphs[3] = hex_glyph(4'd4); glyphs[0] = hex_glyph(sw); end
            DONE: begin
                led = result_q[3:0];
                if (view_q) begin
                    glyphs = {hex_glyph(op_q), hex_glyph(rd1_q), hex_glyph(rd2_q), hex_glyph(wr_q)};
                end else begin
                    glyphs[3] = GLYPH_D;
                    glyphs[0] = hex_glyph(mag);
                    if (unf_q)      glyphs[1] = GLYPH_DASH;
                    else if (ovf_q) glyphs[1] = hex_glyph(4'd1);
                end
            end
            default: disp_en = 1'b0;
        endcase
    end

    microprocessor_top_ssd #(.REFRESH_CYCLES(REFRESH_CYCLES)) u_ssd (
        .clk_i(clk_ref), .rst_i(rst_q), .enable_i(disp_en), .glyph_i(glyphs),
        .seg_o(ssd_seg), .anode_o(ssd_anode)
    );
endmodule

// File: tb/tb_microprocessor_top.sv
// tb/tb_microprocessor_top.sv - self-checking bench for the micro-sequencer top
module tb_microprocessor_top;
    localparam int DEB = 16;
    localparam int REF = 4;
    localparam logic [6:0] G_BLANK = 7'h7F;
    localparam logic [6:0] G_DASH  = 7'h3F;
    localparam logic [6:0] G_D     = 7'h21;

    logic clk_ref = 1'b0;
    always #5 clk_ref = ~clk_ref;

    microprocessor_top_if bus();

    microprocessor_top #(.DEBOUNCE_CYCLES(DEB), .REFRESH_CYCLES(REF)) dut (
        .clk_ref(clk_ref), .btn(bus.btn), .sw(bus.sw), .led(bus.led),
        .ssd_seg(bus.ssd_seg), .ssd_anode(bus.ssd_anode)
    );

    int tests = 0;
    int fails = 0;
    int rf_m [16];
    int exp_res, exp_mag;
    bit exp_ovf, exp_unf;
    logic [6:0] ssd_got [4];
    int ssd_bad;

    function automatic logic [6:0] glyph(input int v);
        logic [6:0] on;
        case (v)
            0: on = 7'h3F;  1: on = 7'h06;  2: on = 7'h5B;  3: on = 7'h4F;
            4: on = 7'h66;  5: on = 7'h6D;  6: on = 7'h7D;  7: on = 7'h07;
            8: on = 7'h7F;  9: on = 7'h6F;  10: on = 7'h77; 11: on = 7'h7C;
            12: on = 7'h39; 13: on = 7'h5E; 14: on = 7'h79; default: on = 7'h71;
        endcase
        return ~on;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_ref);
    endtask

    task automatic press(input logic [3:0] mask, input int hold);
        bus.btn = mask;
        wait_cycles(hold);
        bus.btn = 4'b0000;
        wait_cycles(3 * DEB);
    endtask

    task automatic do_reset();
        bus.btn = 4'b1000;
        wait_cycles(6);
        bus.btn = 4'b0000;
        wait_cycles(6);
        for (int i = 0; i < 16; i++) rf_m[i] = (i == 13) ? 3 : i;
    endtask

    task automatic capture_ssd();
        bit seen [4];
        int n;
        ssd_bad = 0;
        for (int i = 0; i < 4; i++) begin seen[i] = 1'b0; ssd_got[i] = G_BLANK; end
        for (int c = 0; c < 12 * REF; c++) begin
            @(negedge clk_ref);
            n = 0;
            for (int i = 0; i < 4; i++) if (!bus.ssd_anode[i]) n++;
            if (n != 1) ssd_bad++;
            else for (int i = 0; i < 4; i++)
                if (!bus.ssd_anode[i]) begin ssd_got[i] = bus.ssd_seg; seen[i] = 1'b1; end
        end
        for (int i = 0; i < 4; i++) if (!seen[i]) ssd_bad++;
    endtask

    // Reference semantics in plain integer arithmetic
    task automatic model_exec(input int op, input int rd1, input int rd2, input int wr);
        int a, b, r;
        bit we;
        a = rf_m[rd1]; b = rf_m[rd2]; we = 1'b1; exp_ovf = 1'b0; exp_unf = 1'b0;
        case (op)
            0: begin r = 0; we = 1'b0; end
            1: r = rd2;
            2: begin r = a; we = 1'b0; end
            3: r = a;
            4: r = 15 - a;
            5: r = a & b;
            6: r = a | b;
            7: r = a ^ b;
            8: r = 15 - (a & b);
            9: r = 15 - (a | b);
            10: r = a + b;
            11: begin r = a - b; exp_unf = (a < b); end
            12: r = 2 * a;
            13: r = a / 2;
            14: r = a + rd2;
            default: begin r = a - rd2; exp_unf = (a < rd2); end
        endcase
        if (op == 10 || op == 12 || op == 14) exp_ovf = (r > 15);
        exp_mag = exp_unf ? -r : r % 16;
        if (r < 0) r += 16;
        exp_res = r % 16;
        if (we) rf_m[wr] = exp_res;
    endtask

    task automatic run_instr(input int op, input int rd1, input int rd2, input int wr);
        press(4'b0001, 2 * DEB + 8);
        bus.sw = 4'(op);  press(4'b0001, 2 * DEB + 8);
        bus.sw = 4'(rd1); press(4'b0001, 2 * DEB + 8);
        bus.sw = 4'(rd2); press(4'b0001, 2 * DEB + 8);
        bus.sw = 4'(wr);  press(4'b0001, 2 * DEB + 8);
        model_exec(op, rd1, rd2, wr);
    endtask

    task automatic test_reset();
        int bad;
        tests++;
        if (bus.led !== 4'b0000) begin fails++; $display("FAIL reset_led: got %b expected 0000", bus.led); end
        bad = 0;
        for (int c = 0; c < 8 * REF; c++) begin
            @(negedge clk_ref);
            if (bus.ssd_anode !== 4'hF) bad++;
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL reset_anodes: %0d cycles with a lit digit, expected 0", bad); end
    endtask

    task automatic test_entry();
        int v;
        press(4'b0001, 2 * DEB + 8);
        for (int k = 0; k < 4; k++) begin
            v = $urandom_range(0, 15);
            bus.sw = 4'(v);
            wait_cycles(2);
            tests++;
            if (bus.led !== 4'(1 << k)) begin fails++; $display("FAIL entry_led%0d: got %b expected %b", k, bus.led, 4'(1 << k)); end
            capture_ssd();
            tests++;
            if (ssd_bad != 0 || ssd_got[3] !== glyph(k + 1) || ssd_got[0] !== glyph(v) ||
                ssd_got[1] !== G_BLANK || ssd_got[2] !== G_BLANK) begin
                fails++;
                $display("FAIL entry_ssd%0d: got %h %h %h %h bad=%0d expected %h %h %h %h", k,
                         ssd_got[3], ssd_got[2], ssd_got[1], ssd_got[0], ssd_bad, glyph(k + 1), G_BLANK, G_BLANK, glyph(v));
            end
            bus.sw = 4'd0;
            press(4'b0001, 2 * DEB + 8);
        end
        model_exec(0, 0, 0, 0);
        tests++;
        if (bus.led !== 4'b0000) begin fails++; $display("FAIL entry_nop_led: got %b expected 0000", bus.led); end
        press(4'b0001, 2 * DEB + 8);
    endtask

    task automatic test_read_view();
        run_instr(2, 3, 4, 1);
        tests++;
        if (bus.led !== 4'b0011) begin fails++; $display("FAIL read_led: got %b expected 0011", bus.led); end
        capture_ssd();
        tests++;
        if (ssd_bad != 0 || ssd_got[3] !== G_D || ssd_got[2] !== G_BLANK || ssd_got[1] !== G_BLANK || ssd_got[0] !== glyph(3)) begin
            fails++; $display("FAIL read_ssd: got %h %h %h %h bad=%0d", ssd_got[3], ssd_got[2], ssd_got[1], ssd_got[0], ssd_bad);
        end
        press(4'b0010, 2 * DEB + 8);
        capture_ssd();
        tests++;
        if (ssd_bad != 0 || ssd_got[3] !== glyph(2) || ssd_got[2] !== glyph(3) || ssd_got[1] !== glyph(4) || ssd_got[0] !== glyph(1)) begin
            fails++; $display("FAIL instr_view: got %h %h %h %h bad=%0d", ssd_got[3], ssd_got[2], ssd_got[1], ssd_got[0], ssd_bad);
        end
        press(4'b0010, 2 * DEB + 8);
        capture_ssd();
        tests++;
        if (ssd_got[3] !== G_D || ssd_got[0] !== glyph(3)) begin
            fails++; $display("FAIL view_back: got %h %h expected %h %h", ssd_got[3], ssd_got[0], G_D, glyph(3));
        end
        press(4'b0001, 2 * DEB + 8);
        tests++;
        if (bus.led !== 4'b0000 || bus.ssd_anode !== 4'hF) begin
            fails++; $display("FAIL done_to_idle: led %b anode %b expected 0000 1111", bus.led, bus.ssd_anode);
        end
    endtask

    task automatic test_bitwise();
        int expv [5];
        expv = '{2, 7, 5, 13, 8};
        for (int k = 0; k < 5; k++) begin
            run_instr(5 + k, 3, 6, 1);
            tests++;
            if (bus.led !== 4'(expv[k])) begin fails++; $display("FAIL bitwise_op%0d: got %b expected %b", 5 + k, bus.led, 4'(expv[k])); end
            press(4'b0001, 2 * DEB + 8);
            run_instr(2, 1, 0, 0);
            tests++;
            if (bus.led !== 4'(expv[k])) begin fails++; $display("FAIL bitwise_readback%0d: got %b expected %b", 5 + k, bus.led, 4'(expv[k])); end
            press(4'b0001, 2 * DEB + 8);
        end
    endtask

    task automatic test_arith();
        int op_t [4], a_t [4], b_t [4], led_t [4], mag_t [4], fl_t [4];
        logic [6:0] d1;
        op_t = '{10, 10, 14, 11}; a_t = '{3, 15, 3, 3}; b_t = '{13, 6, 13, 6};
        led_t = '{6, 5, 0, 13};   mag_t = '{6, 5, 0, 3}; fl_t = '{0, 1, 1, 2};
        for (int k = 0; k < 4; k++) begin
            run_instr(op_t[k], a_t[k], b_t[k], 1);
            tests++;
            if (bus.led !== 4'(led_t[k])) begin fails++; $display("FAIL arith%0d_led: got %b expected %b", k, bus.led, 4'(led_t[k])); end
            d1 = (fl_t[k] == 2) ? G_DASH : (fl_t[k] == 1) ? glyph(1) : G_BLANK;
            capture_ssd();
            tests++;
            if (ssd_bad != 0 || ssd_got[1] !== d1 || ssd_got[0] !== glyph(mag_t[k]) || ssd_got[3] !== G_D) begin
                fails++; $display("FAIL arith%0d_ssd: got %h %h %h expected %h %h %h", k, ssd_got[3], ssd_got[1], ssd_got[0], G_D, d1, glyph(mag_t[k]));
            end
            press(4'b0001, 2 * DEB + 8);
        end
    endtask

    task automatic test_back_to_back();
        run_instr(3, 5, 0, 2);
        press(4'b0011, 2 * DEB + 8);
        tests++;
        if (bus.led !== 4'b0000) begin fails++; $display("FAIL step_wins_led: got %b expected 0000", bus.led); end
        run_instr(2, 2, 0, 0);
        tests++;
        if (bus.led !== 4'(rf_m[2]) || rf_m[2] != 5) begin fails++; $display("FAIL copy_readback: got %b expected 0101", bus.led); end
        press(4'b0010, 2 * DEB + 8);
        press(4'b0001, 2 * DEB + 8);
        run_instr(2, 2, 0, 0);
        capture_ssd();
        tests++;
        if (ssd_got[3] !== G_D || ssd_got[0] !== glyph(5)) begin
            fails++; $display("FAIL view_cleared: got %h %h expected %h %h", ssd_got[3], ssd_got[0], G_D, glyph(5));
        end
        press(4'b0001, 2 * DEB + 8);
    endtask

    task automatic test_random();
        int op, r1, r2, w;
        logic [6:0] d1;
        for (int n = 0; n < 20; n++) begin
            op = $urandom_range(0, 15); r1 = $urandom_range(0, 15);
            r2 = $urandom_range(0, 15); w = $urandom_range(0, 15);
            run_instr(op, r1, r2, w);
            tests++;
            if (bus.led !== 4'(exp_res)) begin fails++; $display("FAIL rand%0d_led op=%0d: got %b expected %b", n, op, bus.led, 4'(exp_res)); end
            d1 = exp_unf ? G_DASH : exp_ovf ? glyph(1) : G_BLANK;
            capture_ssd();
            tests++;
            if (ssd_bad != 0 || ssd_got[0] !== glyph(exp_mag) || ssd_got[1] !== d1 || ssd_got[3] !== G_D) begin
                fails++; $display("FAIL rand%0d_ssd op=%0d: got %h %h expected %h %h", n, op, ssd_got[1], ssd_got[0], d1, glyph(exp_mag));
            end
            press(4'b0001, 2 * DEB + 8);
        end
    endtask

    task automatic test_regfile_model();
        for (int r = 0; r < 16; r++) begin
            run_instr(2, r, 0, 0);
            tests++;
            if (bus.led !== 4'(rf_m[r])) begin fails++; $display("FAIL regfile_R%0d: got %b expected %b", r, bus.led, 4'(rf_m[r])); end
            press(4'b0001, 2 * DEB + 8);
        end
    endtask

    task automatic test_button_timing();
        bus.btn = 4'b0001;
        wait_cycles(DEB - 4);
        bus.btn = 4'b0000;
        wait_cycles(3 * DEB);
        tests++;
        if (bus.led !== 4'b0000) begin fails++; $display("FAIL glitch: got %b expected 0000", bus.led); end
        bus.btn = 4'b0001;
        wait_cycles(625);
        tests++;
        if (bus.led !== 4'b0001) begin fails++; $display("FAIL long_hold: got %b expected 0001", bus.led); end
        bus.btn = 4'b0000;
        wait_cycles(3 * DEB);
        tests++;
        if (bus.led !== 4'b0001) begin fails++; $display("FAIL long_release: got %b expected 0001", bus.led); end
        bus.sw = 4'd1; press(4'b0001, 2 * DEB + 8);
        bus.sw = 4'd2; press(4'b0001, 2 * DEB + 8);
        bus.sw = 4'd9;
        tests++;
        if (bus.led !== 4'b0100) begin fails++; $display("FAIL pre_reset_rd2: got %b expected 0100", bus.led); end
        do_reset();
        tests++;
        if (bus.led !== 4'b0000 || bus.ssd_anode !== 4'hF) begin
            fails++; $display("FAIL mid_reset: led %b anode %b expected 0000 1111", bus.led, bus.ssd_anode);
        end
        for (int r = 0; r < 16; r++) begin
            run_instr(2, r, 0, 0);
            tests++;
            if (bus.led !== ((r == 13) ? 4'd3 : 4'(r))) begin
                fails++; $display("FAIL reset_table_R%0d: got %b expected %b", r, bus.led, (r == 13) ? 4'd3 : 4'(r));
            end
            press(4'b0001, 2 * DEB + 8);
        end
    endtask

    initial begin
        bus.btn = 4'b0000;
        bus.sw  = 4'd0;
        do_reset();
        test_reset();
        test_entry();
        test_read_view();
        test_bitwise();
        test_arith();
        test_back_to_back();
        test_random();
        test_regfile_model();
        test_button_timing();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/microprocessor_top.md
Name: microprocessor_top

Overview:
- Board-level 4-bit micro-sequencer with a 16x4 register file.
- The user enters one instruction field by field with sw[3:0], stepping with btn[0]. The block executes a 4-bit ALU operation and writes the result back.
- Result and flags appear on led and on a 4-digit multiplexed seven-segment display.
- This is the top module of the FPGA design.

Parameters:
- DEBOUNCE_CYCLES, 256: number of consecutive stable samples needed to accept a button level.
- REFRESH_CYCLES, 64: clk_ref cycles per SSD digit slot.

Ports:
- clk_ref, input, 1: single system clock; all logic is on its rising edge.
- btn, input, 4: push buttons. btn[3] is the reset (synchronous, active-high). btn[0] is step/confirm. btn[1] is the view toggle. btn[2] is unused.
- sw, input, 4: field value (opcode or register index or immediate).
- led, output, 4: status or result.
- ssd_seg, output, 7: segments {g,f,e,d,c,b,a}, active-low.
- ssd_anode, output, 4: digit enables, active-low; bit 0 is the rightmost digit.

Behaviour:
- Buttons btn[0] and btn[1]:
  - Each is 2-flop synchronised, then debounced (level accepted after DEBOUNCE_CYCLES stable samples).
  - One-cycle pulse on the rising edge of the debounced level; one pulse per press regardless of hold length.
- btn[3] reset:
  - Synchronised only, not debounced; acts while high.
  - Sets state to IDLE, clears op/rd1/rd2/wr, result, flags and view, and reloads the register file.
- Register file reset contents: R[i] = i for all i except R[13] = 3.
- FSM states: IDLE -> S_OP -> S_RD1 -> S_RD2 -> S_WR -> DONE -> IDLE.
  - Each transition occurs on a btn[0] pulse.
  - Leaving S_OP/S_RD1/S_RD2/S_WR latches sw into op/rd1/rd2/wr respectively.
  - Leaving S_WR executes. On the same edge the register write happens (if any), and result/flags are latched for DONE.
  - btn[0] in DONE returns to IDLE; latched fields are held.
- Opcodes; A = R[rd1], B = R[rd2], I = rd2 used as an immediate. The result is 5 bits and the low 4 bits are written to R[wr].
  - 0: NOP, no write.
  - 1: LOADI, result = I.
  - 2: READ, result = A, no write.
  - 3: COPY, result = A.
  - 4: NOT A.
  - 5 AND, 6 OR, 7 XOR, 8 NAND, 9 NOR: bitwise on A and B.
  - 10: ADD, A+B.
  - 11: SUB, A-B.
  - 12: SHL, A<<1.
  - 13: SHR, A>>1.
  - 14: ADDI, A+I.
  - 15: SUBI, A-I.
- Flags:
  - ovf = carry out of bit 3 for ADD/ADDI/SHL.
  - unf = (A < operand) for SUB/SUBI; the stored value is the 4-bit two's complement.
  - Both flags are 0 for all other ops.
- led:
  - IDLE: 0000.
  - Entry states: one-hot state index (S_OP = 0001, S_RD1 = 0010, S_RD2 = 0100, S_WR = 1000).
  - DONE: 4-bit result.
- SSD:
  - Multiplexed; each digit lit for REFRESH_CYCLES cycles, rotating 0..3; exactly one anode low at a time.
  - Hex glyphs 0-F; blank = all segments off. No digit is lit in IDLE.
  - Entry states: digit3 = state number (1..4), digit0 = live sw, other digits blank.
  - DONE, result view:
    - digit0 = magnitude in hex.
    - digit1: '-' if unf (digit0 then shows |A-operand|), '1' if ovf, else blank.
    - digit3 = 'd'.
  - btn[1] pulse in DONE toggles the instruction view: digits 3..0 = op, rd1, rd2, wr in hex.
  - Leaving DONE clears the view to result.
- Reset mid-entry abandons the instruction with no register write.
- btn[0] and btn[1] pulsing in the same cycle: btn[0] wins.

Decomposition:
- Package: state enum, opcode constants, register reset table, glyph constants for blank, '-' and 'd'.
- Natural sub-modules: button_conditioner (sync + debounce + edge), instantiated for btn[0] and btn[1]; the seven-segment driver.
- ALU and register file stay inline.

Test Plan:
- Reset -> led = 0000, all anodes high. Then op=2, rd1=3, rd2=4, wr=1 -> DONE: led = 0011, no write, SSD shows "d  3".
- Instruction view: btn[1] in DONE -> SSD digits "2341". A second btn[1] returns to the result view. btn[0] -> IDLE.
- Bitwise ops with R3=0011 and R6=0110, wr=1:
  - AND -> 0010; OR -> 0111; XOR -> 0101; NAND -> 1101; NOR -> 1000.
  - Each result is written to R1; verify with a later READ of R1.
- ADD R3+R13 -> 0110, no ovf. ADD R15+R6 -> led 0101, ovf, SSD digit1 '1'. ADDI R3+13 -> led 0000, ovf.
- SUB R3-R6 -> led 1101 (two's complement), unf, SSD shows "-3".
- Button timing and reset:
  - A btn[0] press held 625 cycles advances exactly one state.
  - A glitch shorter than DEBOUNCE_CYCLES is ignored.
  - btn[3] in S_RD2 -> IDLE with the register file unchanged from its reset table.
